// File: rtl/gpu_instruction_dispatcher_pkg.sv
// Shared opcode map, unit indices, instruction width and dispatcher state encoding.
package gpu_instruction_dispatcher_pkg;

  localparam int WIDTH_BITS   = 12;
  localparam int HEIGHT_BITS  = 12;
  localparam int CHANNEL_BITS = 9;
  localparam int OPCODE_W     = 4;

  // opcode, two x and two y coordinates, RGB colour
  localparam int GPU_INSTR_W   = OPCODE_W + 2*WIDTH_BITS + 2*HEIGHT_BITS + 3*CHANNEL_BITS;
  localparam int GPU_NUM_UNITS = 3;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_RECT   = 4'h1;
  localparam logic [3:0] OP_LINE   = 4'h2;
  localparam logic [3:0] OP_CIRCLE = 4'h3;
  localparam logic [3:0] OP_FENCE  = 4'hF;

  localparam int UNIT_RECT   = 0;
  localparam int UNIT_LINE   = 1;
  localparam int UNIT_CIRCLE = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LATCH,
    ST_ISSUE,
    ST_FENCE
  } disp_state_t;

endpackage

// File: rtl/gpu_opcode_decoder.sv
// Opcode classifier: target unit one-hot plus NOP / FENCE / illegal flags.
// Purely combinational, no backpressure.
module gpu_opcode_decoder
  import gpu_instruction_dispatcher_pkg::*;
#(
  parameter int NUM_UNITS = GPU_NUM_UNITS
) (
  input  logic [3:0]           opcode,
  output logic [NUM_UNITS-1:0] unit_sel,
  output logic                 is_nop,
  output logic                 is_fence,
  output logic                 is_illegal
);

  always_comb begin
    unit_sel   = '0;
    is_nop     = 1'b0;
    is_fence   = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      OP_NOP:    is_nop = 1'b1;
      OP_RECT:   unit_sel[UNIT_RECT] = 1'b1;
      OP_LINE:   unit_sel[UNIT_LINE] = 1'b1;
      OP_CIRCLE: unit_sel[UNIT_CIRCLE] = 1'b1;
      OP_FENCE:  is_fence = 1'b1;
      default:   is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/gpu_instruction_dispatcher.sv
// In-order dispatcher from the instruction FIFO to three draw units, with FENCE drain.
// Pop to start is 2 cycles minimum; a busy target unit stalls the whole stream.
module gpu_instruction_dispatcher
  import gpu_instruction_dispatcher_pkg::*;
#(
  parameter int INSTR_W   = GPU_INSTR_W,
  parameter int NUM_UNITS = GPU_NUM_UNITS,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 dispatch_en_i,
  input  logic                 fifo_empty_i,
  input  logic [INSTR_W-1:0]   instr_i,
  output logic                 pop_instruction_o,
  output logic [INSTR_W-1:0]   cmd_o,
  output logic [NUM_UNITS-1:0] unit_start_o,
  input  logic [NUM_UNITS-1:0] unit_done_i,
  output logic                 fence_done_o,
  output logic                 idle_o,
  output logic                 illegal_o,
  output logic [CNT_W-1:0]     issued_cnt_o,
  output logic [CNT_W-1:0]     illegal_cnt_o
);

  disp_state_t          state;
  logic [INSTR_W-1:0]   hold;
  logic [NUM_UNITS-1:0] pending;
  logic [NUM_UNITS-1:0] unit_sel;
  logic                 is_nop;
  logic                 is_fence;
  logic                 is_illegal;
  logic                 unit_free;

  gpu_opcode_decoder #(.NUM_UNITS(NUM_UNITS)) u_decoder (
    .opcode     (hold[3:0]),
    .unit_sel   (unit_sel),
    .is_nop     (is_nop),
    .is_fence   (is_fence),
    .is_illegal (is_illegal)
  );

  assign unit_free = (pending & unit_sel) == '0;

  // Gated by nrst so the FIFO never sees a pop while the dispatcher is held in reset.
  assign pop_instruction_o = nrst && (state == ST_IDLE) && dispatch_en_i && !fifo_empty_i;
  assign unit_start_o      = (state == ST_ISSUE && unit_free) ? unit_sel : '0;
  assign illegal_o         = (state == ST_LATCH) && is_illegal;
  assign fence_done_o      = (state == ST_FENCE) && (pending == '0);
  assign idle_o            = (state == ST_IDLE) && fifo_empty_i && (pending == '0);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state         <= ST_IDLE;
      hold          <= '0;
      cmd_o         <= '0;
      pending       <= '0;
      issued_cnt_o  <= '0;
      illegal_cnt_o <= '0;
    end else begin
      // A done and a re-issue to the same unit cannot collide: start needs pending clear.
      pending <= (pending & ~unit_done_i) | unit_start_o;
      case (state)
        ST_IDLE: begin
          if (pop_instruction_o) begin
            hold  <= instr_i;
            state <= ST_LATCH;
          end
        end
        ST_LATCH: begin
          if (is_nop) begin
            state <= ST_IDLE;
          end else if (is_illegal) begin
            if (illegal_cnt_o != '1) illegal_cnt_o <= illegal_cnt_o + 1'b1;
            state <= ST_IDLE;
          end else if (is_fence) begin
            state <= ST_FENCE;
          end else begin
            cmd_o <= hold;
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (unit_free) begin
            if (issued_cnt_o != '1) issued_cnt_o <= issued_cnt_o + 1'b1;
            state <= ST_IDLE;
          end
        end
        ST_FENCE: begin
          if (pending == '0) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpu_instruction_dispatcher.sv
// Scoreboard bench: FIFO and draw units are emulated, expected issue/illegal/fence events are queued at push time.
module tb_gpu_instruction_dispatcher;

  localparam int IW = 79;
  localparam int NU = 3;
  localparam int CW = 16;
  localparam int K_ISSUE   = 0;
  localparam int K_ILLEGAL = 1;
  localparam int K_FENCE   = 2;

  typedef struct {
    int            kind;
    int            unit;
    logic [IW-1:0] word;
  } ev_t;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          dispatch_en_i = 1'b1;
  logic          fifo_empty_i = 1'b1;
  logic [IW-1:0] instr_i = '0;
  logic [NU-1:0] unit_done_i = '0;
  logic          pop_instruction_o;
  logic [IW-1:0] cmd_o;
  logic [NU-1:0] unit_start_o;
  logic          fence_done_o;
  logic          idle_o;
  logic          illegal_o;
  logic [CW-1:0] issued_cnt_o;
  logic [CW-1:0] illegal_cnt_o;

  logic [IW-1:0] fifo_q[$];
  ev_t           exp_q[$];
  int            start_log[$];
  int            pop_log[$];
  int            fence_log[$];
  int            ill_seen = 0;
  int            cyc = 0;
  int            vectors = 0;
  int            miscompares = 0;
  int            exp_issued = 0;
  int            exp_illegal = 0;
  logic [NU-1:0] busy = '0;
  int            done_at[NU];
  int            lat_cfg[NU];
  bit            rand_lat = 1'b0;
  bit            spurious = 1'b0;

  gpu_instruction_dispatcher dut (
    .clk               (clk),
    .nrst              (nrst),
    .dispatch_en_i     (dispatch_en_i),
    .fifo_empty_i      (fifo_empty_i),
    .instr_i           (instr_i),
    .pop_instruction_o (pop_instruction_o),
    .cmd_o             (cmd_o),
    .unit_start_o      (unit_start_o),
    .unit_done_i       (unit_done_i),
    .fence_done_o      (fence_done_o),
    .idle_o            (idle_o),
    .illegal_o         (illegal_o),
    .issued_cnt_o      (issued_cnt_o),
    .illegal_cnt_o     (illegal_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_w(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  // Reference model: what the dispatcher must eventually do with each pushed word.
  task automatic push_instr(input logic [3:0] op);
    logic [95:0]   r96;
    logic [IW-1:0] w;
    ev_t           ev;
    r96 = {$urandom, $urandom, $urandom};
    w = {r96[IW-1:4], op};
    fifo_q.push_back(w);
    ev.word = w;
    ev.unit = 0;
    ev.kind = K_ISSUE;
    if (op >= 4'h1 && op <= 4'h3) begin
      ev.unit = int'(op) - 1;
      exp_q.push_back(ev);
      if (exp_issued < 65535) exp_issued++;
    end else if (op == 4'hF) begin
      ev.kind = K_FENCE;
      exp_q.push_back(ev);
    end else if (op != 4'h0) begin
      ev.kind = K_ILLEGAL;
      exp_q.push_back(ev);
      if (exp_illegal < 65535) exp_illegal++;
    end
  endtask

  // Environment: FIFO head and unit completions, driven just after each rising edge.
  initial begin : env
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      fifo_empty_i = (fifo_q.size() == 0);
      instr_i = (fifo_q.size() == 0) ? '0 : fifo_q[0];
      for (int i = 0; i < NU; i++) begin
        unit_done_i[i] = nrst && ((busy[i] && cyc == done_at[i]) ||
                         (spurious && !busy[i] && $urandom_range(0, 9) == 0));
      end
    end
  end

  // Monitor: observes every DUT event mid-cycle and checks it against the expected queue.
  initial begin : monitor
    ev_t           ev;
    int            u;
    logic [IW-1:0] dummy;
    forever begin
      @(negedge clk);
      if (!nrst) begin
        busy = '0;
      end else begin
        for (int i = 0; i < NU; i++)
          if (busy[i] && cyc == done_at[i]) busy[i] = 1'b0;
        if (pop_instruction_o) begin
          if (fifo_empty_i || !dispatch_en_i) flag("pop_not_allowed");
          else begin
            dummy = fifo_q.pop_front();
            pop_log.push_back(cyc);
          end
        end
        if (unit_start_o != '0) begin
          u = 0;
          for (int i = 0; i < NU; i++) if (unit_start_o[i]) u = i;
          if (!$onehot(unit_start_o)) flag("start_not_onehot");
          if (busy[u]) flag("start_while_unit_busy");
          busy[u] = 1'b1;
          done_at[u] = cyc + (rand_lat ? int'($urandom_range(1, 12)) : lat_cfg[u]);
          start_log.push_back(cyc);
          if (exp_q.size() == 0) flag("unexpected_start");
          else begin
            ev = exp_q.pop_front();
            check("event_kind_start", K_ISSUE, ev.kind);
            check("start_unit", u, ev.unit);
            check_w("cmd_word", cmd_o, ev.word);
          end
        end
        if (illegal_o) begin
          ill_seen++;
          if (exp_q.size() == 0) flag("unexpected_illegal");
          else begin
            ev = exp_q.pop_front();
            check("event_kind_illegal", K_ILLEGAL, ev.kind);
          end
        end
        if (fence_done_o) begin
          fence_log.push_back(cyc);
          check("fence_units_drained", busy, 0);
          if (exp_q.size() == 0) flag("unexpected_fence_done");
          else begin
            ev = exp_q.pop_front();
            check("event_kind_fence", K_FENCE, ev.kind);
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_starts(input int n, input int budget, input string name);
    int k = 0;
    while (start_log.size() < n && k < budget) begin
      tick();
      k++;
    end
    if (start_log.size() < n) flag(name);
  endtask

  task automatic wait_pops(input int n, input int budget, input string name);
    int k = 0;
    while (pop_log.size() < n && k < budget) begin
      tick();
      k++;
    end
    if (pop_log.size() < n) flag(name);
  endtask

  task automatic drain(input int budget, input string name);
    int k = 0;
    while (!(fifo_q.size() == 0 && exp_q.size() == 0 && idle_o && busy == '0) && k < budget) begin
      tick();
      k++;
    end
    if (!(fifo_q.size() == 0 && exp_q.size() == 0 && idle_o && busy == '0)) flag(name);
  endtask

  task automatic clear_logs();
    start_log.delete();
    pop_log.delete();
    fence_log.delete();
  endtask

  initial begin : main
    int rel;
    int ill_before;
    logic [3:0] op;
    int r;
    lat_cfg[0] = 4;
    lat_cfg[1] = 4;
    lat_cfg[2] = 4;

    repeat (3) tick();
    check("rst_pop", pop_instruction_o, 0);
    check("rst_cmd", cmd_o, 0);
    check("rst_start", unit_start_o, 0);
    check("rst_fence_done", fence_done_o, 0);
    check("rst_illegal", illegal_o, 0);
    check("rst_issued_cnt", issued_cnt_o, 0);
    check("rst_illegal_cnt", illegal_cnt_o, 0);
    check("rst_idle_empty", idle_o, 1);

    // Rect waiting in the FIFO across reset release
    clear_logs();
    push_instr(4'h1);
    tick();
    tick();
    check("rst_idle_nonempty", idle_o, 0);
    check("rst_pop_held", pop_instruction_o, 0);
    @(posedge clk);
    #2;
    nrst = 1'b1;
    rel = cyc;
    wait_starts(1, 20, "t1_start_timeout");
    tick();
    if (start_log.size() >= 1 && pop_log.size() >= 1) begin
      check("t1_pop_cycle", pop_log[0] - rel, 0);
      check("t1_start_cycle", start_log[0] - rel, 2);
    end
    check("t1_issued_cnt", issued_cnt_o, exp_issued);
    drain(100, "t1_drain_timeout");

    // line, line, rect with slow line unit
    lat_cfg[1] = 10;
    lat_cfg[0] = 3;
    clear_logs();
    push_instr(4'h2);
    push_instr(4'h2);
    push_instr(4'h1);
    drain(200, "t2_drain_timeout");
    check("t2_starts", start_log.size(), 3);
    if (start_log.size() >= 3) begin
      check("t2_second_line_after_done", start_log[1] - start_log[0], 11);
      check("t2_rect_after_second_line", start_log[2] - start_log[1], 3);
    end

    // rect then FENCE, rect done 18 cycles after its start
    lat_cfg[0] = 18;
    clear_logs();
    push_instr(4'h1);
    push_instr(4'hF);
    drain(200, "t3_drain_timeout");
    check("t3_fences", fence_log.size(), 1);
    if (fence_log.size() >= 1 && start_log.size() >= 1)
      check("t3_fence_after_done", fence_log[0] - start_log[0], 19);
    tick();
    check("t3_idle_after_fence", idle_o, 1);

    // illegal opcode then NOP
    lat_cfg[0] = 3;
    clear_logs();
    ill_before = ill_seen;
    push_instr(4'h7);
    push_instr(4'h0);
    drain(100, "t4_drain_timeout");
    check("t4_illegal_pulses", ill_seen - ill_before, 1);
    check("t4_illegal_cnt", illegal_cnt_o, exp_illegal);
    check("t4_no_start", start_log.size(), 0);
    check("t4_pops", pop_log.size(), 2);

    // dispatch disabled during LATCH of a circle
    clear_logs();
    push_instr(4'h3);
    push_instr(4'h1);
    wait_pops(1, 20, "t5_pop_timeout");
    @(posedge clk);
    #2;
    dispatch_en_i = 1'b0;
    repeat (12) tick();
    check("t5_circle_issued", start_log.size(), 1);
    check("t5_pops_while_disabled", pop_log.size(), 1);
    check("t5_fifo_left", fifo_q.size(), 1);
    @(posedge clk);
    #2;
    dispatch_en_i = 1'b1;
    drain(100, "t5_drain_timeout");
    check("t5_rect_issued", start_log.size(), 2);

    // reset while the circle unit is pending
    lat_cfg[2] = 60;
    clear_logs();
    push_instr(4'h3);
    wait_starts(1, 20, "t6_start_timeout");
    repeat (3) tick();
    @(posedge clk);
    #2;
    nrst = 1'b0;
    exp_issued = 0;
    exp_illegal = 0;
    tick();
    check("t6_issued_cnt", issued_cnt_o, 0);
    check("t6_illegal_cnt", illegal_cnt_o, 0);
    check("t6_cmd", cmd_o, 0);
    check("t6_idle", idle_o, 1);
    clear_logs();
    lat_cfg[2] = 4;
    push_instr(4'h3);
    tick();
    @(posedge clk);
    #2;
    nrst = 1'b1;
    rel = cyc;
    wait_starts(1, 20, "t6_restart_timeout");
    if (start_log.size() >= 1) check("t6_restart_latency", start_log[0] - rel, 2);
    drain(100, "t6_drain_timeout");
    check("t6_issued_after", issued_cnt_o, exp_issued);

    // randomized traffic, random unit latencies, stray done pulses, enable toggling
    rand_lat = 1'b1;
    spurious = 1'b1;
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      if (r < 6) op = 4'(r % 3 + 1);
      else if (r == 6) op = 4'h0;
      else if (r == 7) op = 4'hF;
      else op = 4'($urandom_range(4, 14));
      push_instr(op);
      @(posedge clk);
      #2;
      if ($urandom_range(0, 3) == 0) dispatch_en_i = ~dispatch_en_i;
      repeat ($urandom_range(0, 4)) tick();
    end
    @(posedge clk);
    #2;
    dispatch_en_i = 1'b1;
    drain(20000, "rand_drain_timeout");
    check("rand_issued_cnt", issued_cnt_o, exp_issued);
    check("rand_illegal_cnt", illegal_cnt_o, exp_illegal);
    check("rand_idle", idle_o, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
